// File: rtl/mcore_pkg.sv
// Shared types and constants for the multi-cycle MIPS core.
// Opcodes, funct codes, state and ALU-op enums.
package mcore_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] REG_LINK = 5'd31;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mcore_if.sv
// Unified instruction/data memory port, req/ready handshake.
// The core is the master; memory or bus bridge is the slave.
interface mcore_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mcore_regfile.sv
// 32x32 register file: two async reads, one sync write.
// r0 reads as zero; contents cleared by reset.
module mcore_regfile (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/multi_cycle_mips_core.sv
// Multi-cycle MIPS subset core over one shared memory port.
// Define MCORE_PERF_CNT_EN to add cycle/retired counters.
module multi_cycle_mips_core
  import mcore_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  mcore_if.master     mem,
  output logic        halted
`ifdef MCORE_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_retired
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       res_q, res_d;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign op  = ir_q[31:26];
  assign rs  = ir_q[25:21];
  assign rt  = ir_q[20:16];
  assign rd  = ir_q[15:11];
  assign fn  = ir_q[5:0];
  assign imm = ir_q[15:0];

  logic is_r, is_jr, is_alur, is_addi, is_lw, is_sw;
  logic is_beq, is_bne, is_j, is_jal, legal;

  assign is_r    = (op == OP_RTYPE);
  assign is_jr   = is_r && (fn == FN_JR);
  assign is_alur = is_r && ((fn == FN_ADD) || (fn == FN_SUB) ||
                   (fn == FN_AND) || (fn == FN_OR) || (fn == FN_SLT));
  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
  assign legal   = is_alur | is_jr | is_addi | is_lw | is_sw |
                   is_beq | is_bne | is_j | is_jal;

  logic [31:0] rs_val, rt_val;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  mcore_regfile u_rf (
    .clk    (clk),
    .reset_n(reset_n),
    .ra1_i  (rs),
    .ra2_i  (rt),
    .rd1_o  (rs_val),
    .rd2_o  (rt_val),
    .we_i   (rf_we),
    .wa_i   (rf_wa),
    .wd_i   (rf_wd)
  );

  // pc_q already holds PC+4 once the fetch has completed
  logic [31:0]       j_tgt32;
  logic [ADDR_W-1:0] j_tgt, br_tgt;

  assign j_tgt32 = (32'(pc_q) & 32'hF000_0000) |
                   {4'b0, ir_q[25:0], 2'b00};
  assign j_tgt   = ADDR_W'(j_tgt32);
  assign br_tgt  = pc_q + ADDR_W'(sext16(imm) << 2);

  function automatic logic [31:0] alu(
    input alu_op_e     f,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [31:0] r;
    r = x + y;
    unique case (f)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = {31'b0, $signed(x) < $signed(y)};
      default: r = x + y;
    endcase
    return r;
  endfunction

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;

  always_comb begin
    alu_op = ALU_ADD;
    if (is_r) begin
      case (fn)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign alu_b = is_r ? b_q : sext16(imm);
  assign alu_y = alu(alu_op, a_q, alu_b);

  assign mem.mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem.mem_we    = (state_q == S_MEM) && is_sw;
  assign mem.mem_addr  = (state_q == S_MEM) ? ADDR_W'(res_q) : pc_q;
  assign mem.mem_wdata = b_q;
  assign halted        = (state_q == S_HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    rf_we   = 1'b0;
    rf_wa   = rt;
    rf_wd   = res_q;
    unique case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs_val;
        b_d     = rt_val;
        state_d = S_EXEC;
        unique case (1'b1)
          !legal: state_d = S_HALT;
          is_j: begin
            pc_d    = j_tgt;
            state_d = S_FETCH;
          end
          is_jal: begin
            pc_d    = j_tgt;
            state_d = S_FETCH;
            rf_we   = 1'b1;
            rf_wa   = REG_LINK;
            rf_wd   = 32'(pc_q);
          end
          is_jr: begin
            if (rs_val[1:0] != 2'b00) begin
              state_d = S_HALT;
            end else begin
              pc_d    = ADDR_W'(rs_val);
              state_d = S_FETCH;
            end
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        res_d = alu_y;
        unique case (1'b1)
          is_lw, is_sw: begin
            state_d = (alu_y[1:0] != 2'b00) ? S_HALT : S_MEM;
          end
          is_beq: begin
            if (a_q == b_q) pc_d = br_tgt;
            state_d = S_FETCH;
          end
          is_bne: begin
            if (a_q != b_q) pc_d = br_tgt;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          if (is_sw) begin
            state_d = S_FETCH;
          end else begin
            res_d   = mem.mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wa   = is_r ? rd : rt;
        rf_wd   = res_q;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

`ifdef MCORE_PERF_CNT_EN
  logic        retire;
  logic [31:0] cyc_q, ret_q;

  // An instruction retires in whichever state is its last one
  assign retire =
    ((state_q == S_DECODE) &&
     (is_j || is_jal || (is_jr && (rs_val[1:0] == 2'b00)))) ||
    ((state_q == S_EXEC) && (is_beq || is_bne)) ||
    ((state_q == S_MEM) && is_sw && mem.mem_ready) ||
    (state_q == S_WB);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != S_HALT) cyc_q <= cyc_q + 32'd1;
      if (retire) ret_q <= ret_q + 32'd1;
    end
  end

  assign perf_cycles  = cyc_q;
  assign perf_retired = ret_q;
`endif

endmodule
